// File: rtl/r_rom_pkg.sv
// Shared definitions for the ROM read path: FSM states, byte counts and the
// fill pattern returned when a ROM read times out.
package r_rom_pkg;

    typedef enum logic [1:0] {
        S_CMD = 2'd0,
        S_REQ = 2'd1,
        S_RSP = 2'd2
    } state_e;

    localparam int          CMD_BYTES = 8;
    localparam int          RSP_BYTES = 8;
    localparam logic [63:0] ERR_DATA  = 64'hFFFF_FFFF_FFFF_FFFF;

    // True when a 4-bit byte counter has just reached the last byte of a word.
    function automatic logic is_last_byte(input logic [3:0] cnt, input int total);
        return cnt == 4'(total - 1);
    endfunction

endpackage

// File: rtl/r_rom_shift64.sv
// 64-bit byte shift register. A shift moves the word down one byte and inserts
// shift_in at the top, so eight shifts assemble a little-endian word (address
// deserialiser) or stream a word out low byte first (data serialiser).
module r_rom_shift64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        shift,
    input  logic [7:0]  shift_in,
    output logic [63:0] q
);

    logic [63:0] q_q;
    logic [63:0] q_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift) begin
            q_d = {shift_in, q_q[63:8]};
        end
    end

    // Word register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/r_rom_backend.sv
// ROM backend: pops an 8-byte little-endian address from the command FIFO,
// performs one 64-bit ROM read (or flags out-of-range / timeout), and pushes
// the 8 data bytes, low byte first, into the response FIFO. One command at a
// time.
//
// Handshakes: a FIFO pop/push happens on every cycle its enable is high; the
// enables already include ~cmd_empty / ~rsp_full. rom_req is held high until
// the cycle rom_ack is seen (or the wait times out); rom_rdata is taken in the
// ack cycle.
module r_rom_backend
    import r_rom_pkg::*;
#(
    parameter int          ROM_AW      = 12,
    parameter logic [63:0] ROM_BASE    = 64'h0000_0000_0000_1000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_empty,
    output logic              cmd_rd_en,
    input  logic [7:0]        cmd_dout,
    input  logic              rsp_full,
    output logic              rsp_wr_en,
    output logic [7:0]        rsp_din,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [63:0]       rom_rdata,
    output logic              err
);

    localparam int                WAIT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);

    state_e              state_q, state_d;
    logic [3:0]          issued_q, issued_d;
    logic [3:0]          rx_q, rx_d;
    logic [3:0]          tx_q, tx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                pend_q, pend_d;
    logic                rom_req_q, rom_req_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic                err_q, err_d;

    logic [63:0]         addr_word;
    logic [63:0]         data_word;
    logic                data_load;
    logic [63:0]         data_load_val;
    logic                data_shift;

    logic [63:0]         addr_next;
    logic [60:0]         word_off;
    logic                in_range;
    logic                last_capture;
    logic                ack_hit;
    logic                timeout_hit;
    logic                unused_bits;

    // Address deserialiser: each captured command byte enters at the top.
    r_rom_shift64 u_addr_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data (64'h0),
        .shift     (pend_q),
        .shift_in  (cmd_dout),
        .q         (addr_word)
    );

    // Data serialiser: loaded with the read result, drained low byte first.
    r_rom_shift64 u_data_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (data_load),
        .load_data (data_load_val),
        .shift     (data_shift),
        .shift_in  (8'h00),
        .q         (data_word)
    );

    // Range decode on the address as it will look once the current byte lands,
    // so the request can be raised on the same edge that captures the 8th byte.
    always_comb begin
        addr_next    = {cmd_dout, addr_word[63:8]};
        word_off     = addr_next[63:3] - ROM_BASE[63:3];
        in_range     = (addr_next[63:3] >= ROM_BASE[63:3]) && (word_off[60:ROM_AW] == '0);
        last_capture = pend_q && is_last_byte(rx_q, CMD_BYTES);
        ack_hit      = (state_q == S_REQ) && rom_ack;
        timeout_hit  = (state_q == S_REQ) && !rom_ack && (wait_q == WAIT_MAX);
    end

    // Low address bits select a byte within the word and are not needed.
    assign unused_bits = ^{addr_word[7:0], addr_next[2:0], data_word[63:8]};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CMD: if (last_capture) state_d = in_range ? S_REQ : S_RSP;
            S_REQ: if (ack_hit || timeout_hit) state_d = S_RSP;
            S_RSP: if (rsp_wr_en && is_last_byte(tx_q, RSP_BYTES)) state_d = S_CMD;
            default: state_d = S_CMD;
        endcase
    end

    // FSM outputs: FIFO enables, gated by reset so they read 0 while held.
    always_comb begin
        cmd_rd_en = 1'b0;
        rsp_wr_en = 1'b0;
        case (state_q)
            S_CMD:   cmd_rd_en = rst_n & ~cmd_empty & (issued_q < 4'(CMD_BYTES));
            S_RSP:   rsp_wr_en = rst_n & ~rsp_full;
            default: ;
        endcase
    end

    // Counters, request/address/error registers and serialiser controls.
    always_comb begin
        issued_d      = issued_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        wait_d        = '0;
        pend_d        = 1'b0;
        rom_req_d     = rom_req_q;
        rom_addr_d    = rom_addr_q;
        err_d         = 1'b0;
        data_load     = 1'b0;
        data_load_val = '0;
        data_shift    = 1'b0;
        case (state_q)
            S_CMD: begin
                pend_d   = cmd_rd_en;
                issued_d = issued_q + 4'(cmd_rd_en);
                rx_d     = rx_q + 4'(pend_q);
                if (last_capture) begin
                    if (in_range) begin
                        rom_addr_d = word_off[ROM_AW-1:0];
                        rom_req_d  = 1'b1;
                    end else begin
                        data_load     = 1'b1;
                        data_load_val = 64'h0;
                        err_d         = 1'b1;
                    end
                end
            end
            S_REQ: begin
                wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
                if (rom_ack) begin
                    data_load     = 1'b1;
                    data_load_val = rom_rdata;
                    rom_req_d     = 1'b0;
                end else if (wait_q == WAIT_MAX) begin
                    data_load     = 1'b1;
                    data_load_val = ERR_DATA;
                    err_d         = 1'b1;
                    rom_req_d     = 1'b0;
                end
            end
            S_RSP: begin
                if (rsp_wr_en) begin
                    data_shift = 1'b1;
                    if (is_last_byte(tx_q, RSP_BYTES)) begin
                        issued_d = '0;
                        rx_d     = '0;
                        tx_d     = '0;
                    end else begin
                        tx_d = tx_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q   <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            wait_q     <= '0;
            pend_q     <= 1'b0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            issued_q   <= issued_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            wait_q     <= wait_d;
            pend_q     <= pend_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            err_q      <= err_d;
        end
    end

    assign rsp_din  = data_word[7:0];
    assign rom_req  = rom_req_q;
    assign rom_addr = rom_addr_q;
    assign err      = err_q;

endmodule

// File: tb/tb_r_rom_backend.sv
// Bench for r_rom_backend: models the command FIFO, response FIFO and ROM,
// predicts the response bytes of every command from the address rules, and
// checks pushes, requests, error pulses and timing against those predictions.
module tb_r_rom_backend;

  localparam int          ROM_AW      = 12;
  localparam logic [63:0] ROM_BASE    = 64'h0000_0000_0000_1000;
  localparam int          ACK_TIMEOUT = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_empty = 1'b1;
  logic              cmd_rd_en;
  logic [7:0]        cmd_dout = 8'h00;
  logic              rsp_full = 1'b0;
  logic              rsp_wr_en;
  logic [7:0]        rsp_din;
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack = 1'b0;
  logic [63:0]       rom_rdata = 64'h0;
  logic              err;

  r_rom_backend #(
    .ROM_AW      (ROM_AW),
    .ROM_BASE    (ROM_BASE),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_empty (cmd_empty),
    .cmd_rd_en (cmd_rd_en),
    .cmd_dout  (cmd_dout),
    .rsp_full  (rsp_full),
    .rsp_wr_en (rsp_wr_en),
    .rsp_din   (rsp_din),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_ack   (rom_ack),
    .rom_rdata (rom_rdata),
    .err       (err)
  );

  // ---------------- model state ----------------
  int checks = 0;
  int errors = 0;

  logic [63:0]       mem [0:4095];
  logic [7:0]        cmd_fifo[$];
  logic [7:0]        exp_q[$];
  logic [ROM_AW-1:0] exp_addr_q[$];
  int                ack_plan_q[$];

  int exp_err = 0, seen_err = 0;
  int cyc = 0, pop_cnt = 0, push_cnt = 0, push_total = 0;
  int last_pop_cyc = 0, first_push_cyc = 0, last_push_cyc = 0;
  bit toggle_empty = 0, hold_full = 0, spurious_ack = 0;
  int empty_pct = 0, full_pct = 0;
  logic [7:0] next_dout = 8'h00;
  bit req_active = 0;
  int req_cycles = 0, plan = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Queue one command; ack_plan = cycle of rom_req on which to ack, <0 = never.
  task automatic send_cmd(input logic [63:0] addr, input int ack_plan);
    logic [63:0] idx;
    logic [63:0] word;
    bit in_rng;
    in_rng = (addr >= ROM_BASE) && (((addr - ROM_BASE) >> 3) < (64'd1 << ROM_AW));
    idx = (addr - ROM_BASE) >> 3;
    if (in_rng) begin
      exp_addr_q.push_back(idx[ROM_AW-1:0]);
      ack_plan_q.push_back(ack_plan);
      if (ack_plan < 0) begin
        word = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_err++;
      end else begin
        word = mem[idx[11:0]];
      end
    end else begin
      word = 64'h0;
      exp_err++;
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(word[8*i +: 8]);
    for (int i = 0; i < 8; i++) cmd_fifo.push_back(addr[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((cmd_fifo.size() != 0 || exp_q.size() != 0 || pop_cnt != 0) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk({tag, "_idle_in_time"}, n < budget, 1);
    repeat (3) begin @(negedge clk); #2; end
  endtask

  task automatic wait_pushes(input int target, input int budget);
    int n;
    n = 0;
    while (push_total < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk("push_wait_in_time", n < budget, 1);
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!rom_req && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk("req_wait_in_time", n < budget, 1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_cmd_rd_en"}, cmd_rd_en, 0);
    chk({tag, "_rsp_wr_en"}, rsp_wr_en, 0);
    chk({tag, "_rsp_din"}, rsp_din, 0);
    chk({tag, "_rom_req"}, rom_req, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_err"}, err, 0);
    cmd_fifo.delete(); exp_q.delete(); exp_addr_q.delete(); ack_plan_q.delete();
    exp_err = 0; seen_err = 0; pop_cnt = 0; push_cnt = 0; req_active = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- FIFO/ROM model and scoreboard ----------------
  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  always begin
    @(negedge clk);
    cmd_dout  = next_dout;
    cmd_empty = (cmd_fifo.size() == 0) || (toggle_empty && cyc[0]) ||
                ($urandom_range(99) < empty_pct);
    rsp_full  = hold_full || ($urandom_range(99) < full_pct);
    rom_ack   = 1'b0;
    rom_rdata = {$urandom, $urandom};
    if (rst_n && rom_req) begin
      if (!req_active) begin
        req_active = 1;
        req_cycles = 0;
        if (ack_plan_q.size() == 0) begin
          chk("unexpected_rom_req", 1, 0);
          plan = 1;
        end else begin
          plan = ack_plan_q.pop_front();
        end
        if (exp_addr_q.size() != 0) chk("rom_addr", rom_addr, exp_addr_q.pop_front());
      end
      req_cycles++;
      if (plan > 0 && req_cycles >= plan) begin
        rom_ack   = 1'b1;
        rom_rdata = mem[rom_addr];
      end
    end else if (spurious_ack) begin
      rom_ack = 1'($urandom_range(1));
    end
    #1;
    if (rst_n) begin
      if (rom_req && rom_ack) begin
        req_active = 0;
      end else if (!rom_req && req_active) begin
        chk("timeout_length", (req_cycles == ACK_TIMEOUT) || (req_cycles == ACK_TIMEOUT + 1), 1);
        req_active = 0;
      end
      if (cmd_rd_en) begin
        chk("pop_legal", !cmd_empty && pop_cnt < 8 && !rom_req, 1);
        if (cmd_fifo.size() != 0) next_dout = cmd_fifo.pop_front();
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (rsp_wr_en) begin
        chk("push_legal", !rsp_full && pop_cnt == 8, 1);
        if (exp_q.size() == 0) chk("push_unexpected", 1, 0);
        else chk("rsp_din", rsp_din, exp_q.pop_front());
        if (push_cnt == 0) first_push_cyc = cyc;
        if (push_cnt == 7) last_push_cyc = cyc;
        push_cnt++;
        push_total++;
        if (push_cnt == 8) begin
          push_cnt = 0;
          pop_cnt  = 0;
        end
      end
      if (err) seen_err++;
    end
    cyc++;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [63:0] a;
    int r;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    mem[1] = 64'h8877_6655_4433_2211;

    // Reset values.
    repeat (3) @(negedge clk);
    #2;
    chk("rst_cmd_rd_en", cmd_rd_en, 0);
    chk("rst_rsp_wr_en", rsp_wr_en, 0);
    chk("rst_rsp_din", rsp_din, 0);
    chk("rst_rom_req", rom_req, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); #2; end

    // 1: basic read, ack on first request cycle, latency.
    send_cmd(64'h1008, 1);
    wait_idle("t1", 500);
    chk("t1_first_push_latency", first_push_cyc - last_pop_cyc, 3);
    chk("t1_last_push_latency", last_push_cyc - first_push_cyc, 7);
    chk("t1_err_count", seen_err, exp_err);

    // 2: below base.
    send_cmd(64'h0FF8, 1);
    wait_idle("t2", 500);
    chk("t2_err_count", seen_err, exp_err);

    // 3: ack never arrives.
    send_cmd(64'h1028, -1);
    wait_idle("t3", 1000);
    chk("t3_err_count", seen_err, exp_err);

    // 4: command FIFO empty every other cycle, response FIFO full for 20 cycles.
    toggle_empty = 1;
    send_cmd(64'h1323, 3);
    wait_pushes(push_total + 3, 500);
    hold_full = 1;
    repeat (20) begin @(negedge clk); #2; end
    hold_full = 0;
    wait_idle("t4", 500);
    toggle_empty = 0;
    chk("t4_err_count", seen_err, exp_err);

    // 5: reset during request, reset mid-response, then a clean command.
    send_cmd(64'h1040, -1);
    wait_req(200);
    do_reset("t5a");
    send_cmd(64'h1048, 2);
    wait_pushes(push_total + 4, 500);
    do_reset("t5b");
    send_cmd(64'h8FF8, 1);
    wait_idle("t5", 500);
    chk("t5_err_count", seen_err, exp_err);

    // 6: back-to-back commands, third out of range; then the upper boundary.
    send_cmd(64'h1000, 1);
    send_cmd(64'h1010, 2);
    send_cmd(64'h1FFF8, 1);
    wait_idle("t6", 1000);
    chk("t6_err_count", seen_err, exp_err);
    send_cmd(64'h9000, 1);
    send_cmd(64'h8FFF, 4);
    wait_idle("t6b", 1000);
    chk("t6b_err_count", seen_err, exp_err);

    // Random traffic with random FIFO stalls and stray acks.
    empty_pct = 30; full_pct = 30; spurious_ack = 1;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(9);
      if (r == 0) begin
        a = 64'($urandom_range(32'h0FFF));
        send_cmd(a, 1);
      end else if (r == 1) begin
        a = {$urandom, $urandom} | 64'h0000_0000_0001_0000;
        send_cmd(a, 1);
      end else if (r == 2) begin
        a = ROM_BASE + 64'($urandom_range(4095)) * 8 + 64'($urandom_range(7));
        send_cmd(a, -1);
      end else begin
        a = ROM_BASE + 64'($urandom_range(4095)) * 8 + 64'($urandom_range(7));
        send_cmd(a, int'($urandom_range(1, 6)));
      end
    end
    wait_idle("rand", 20000);
    chk("rand_err_count", seen_err, exp_err);
    empty_pct = 0; full_pct = 0; spurious_ack = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
